// File: rtl/pipelined_control_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_control_unit_if : ID->EX control bundle (instruction in, decoded controls out)
// Revision 1.0
// ---------------------------------------------------------------------------
interface pipelined_control_unit_if #(
  parameter int ALUOP_W   = 5,
  parameter int IMM_SEL_W = 3
);
  logic [31:0]          INSTRUCTION;
  logic                 IN_VALID;
  logic                 STALL;
  logic                 FLUSH;
  logic [ALUOP_W-1:0]   ALUOP;
  logic [IMM_SEL_W-1:0] IMME_SELECT;
  logic                 MUX1_SELECT;
  logic                 MUX2_SELECT;
  logic                 MUX3_SELECT;
  logic                 MUX4_SELECT;
  logic                 WRITEENABLE;
  logic                 MEMREAD;
  logic                 MEMWRITE;
  logic                 BRANCH;
  logic                 JUMP;
  logic [2:0]           FUNCT3_OUT;
  logic                 OUT_VALID;
  logic                 ILLEGAL;
  logic                 MD_BUSY;

  modport master (
    output INSTRUCTION, IN_VALID, STALL, FLUSH,
    input  ALUOP, IMME_SELECT, MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT,
    input  WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP, FUNCT3_OUT,
    input  OUT_VALID, ILLEGAL, MD_BUSY
  );

  modport slave (
    input  INSTRUCTION, IN_VALID, STALL, FLUSH,
    output ALUOP, IMME_SELECT, MUX1_SELECT, MUX2_SELECT, MUX3_SELECT, MUX4_SELECT,
    output WRITEENABLE, MEMREAD, MEMWRITE, BRANCH, JUMP, FUNCT3_OUT,
    output OUT_VALID, ILLEGAL, MD_BUSY
  );
endinterface
`default_nettype wire

// File: rtl/pipelined_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipelined_control_unit : registered RV32I ID/EX decoder; M-ops + MD_BUSY hold when RV32M_EN is defined
// Revision 1.0
// ---------------------------------------------------------------------------
module pipelined_control_unit #(
  parameter int ALUOP_W    = 5,
  parameter int IMM_SEL_W  = 3,
  parameter int MD_LATENCY = 4
) (
  input  wire logic               CLK,
  input  wire logic               RESET,
  pipelined_control_unit_if.slave bus
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  localparam logic [ALUOP_W-1:0] c_ALU_PASS_B = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] c_ALU_ADD    = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] c_ALU_SUB    = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] c_ALU_SLL    = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] c_ALU_SLT    = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] c_ALU_SLTU   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] c_ALU_XOR    = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] c_ALU_SRL    = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] c_ALU_SRA    = ALUOP_W'(8);
  localparam logic [ALUOP_W-1:0] c_ALU_OR     = ALUOP_W'(9);
  localparam logic [ALUOP_W-1:0] c_ALU_AND    = ALUOP_W'(10);

  localparam logic [IMM_SEL_W-1:0] c_IMM_I = IMM_SEL_W'(0);
  localparam logic [IMM_SEL_W-1:0] c_IMM_S = IMM_SEL_W'(1);
  localparam logic [IMM_SEL_W-1:0] c_IMM_U = IMM_SEL_W'(2);
  localparam logic [IMM_SEL_W-1:0] c_IMM_B = IMM_SEL_W'(3);
  localparam logic [IMM_SEL_W-1:0] c_IMM_J = IMM_SEL_W'(4);

  typedef struct packed {
    logic [ALUOP_W-1:0]   aluop;
    logic [IMM_SEL_W-1:0] imm;
    logic                 mux1;
    logic                 mux2;
    logic                 mux3;
    logic                 mux4;
    logic                 we;
    logic                 mr;
    logic                 mw;
    logic                 br;
    logic                 jp;
    logic [2:0]           f3;
    logic                 valid;
    logic                 illegal;
  } ctl_t;

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal;
  logic       w_unused_bits;
  ctl_t       w_dec;
  ctl_t       r_ctl;

  assign w_opc         = bus.INSTRUCTION[6:0];
  assign w_f3          = bus.INSTRUCTION[14:12];
  assign w_f7          = bus.INSTRUCTION[31:25];
  assign w_unused_bits = ^{bus.INSTRUCTION[24:15], bus.INSTRUCTION[11:7]};

  function automatic logic [ALUOP_W-1:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = c_ALU_ADD;
      3'b001:  base_op = c_ALU_SLL;
      3'b010:  base_op = c_ALU_SLT;
      3'b011:  base_op = c_ALU_SLTU;
      3'b100:  base_op = c_ALU_XOR;
      3'b101:  base_op = c_ALU_SRL;
      3'b110:  base_op = c_ALU_OR;
      default: base_op = c_ALU_AND;
    endcase
  endfunction

`ifdef RV32M_EN
  localparam logic [ALUOP_W-1:0] c_ALU_MUL = ALUOP_W'(11);
  logic w_is_mop;
`endif

  always_comb begin
    w_dec   = '0;
    w_legal = 1'b1;
`ifdef RV32M_EN
    w_is_mop = 1'b0;
`endif
    case (w_opc)
      c_OPC_OP: begin
        w_dec.we = 1'b1;
        w_dec.f3 = w_f3;
        if (w_f7 == 7'b0000000) begin
          w_dec.aluop = base_op(w_f3);
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
          w_dec.aluop = c_ALU_SUB;
        end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
          w_dec.aluop = c_ALU_SRA;
`ifdef RV32M_EN
        end else if (w_f7 == 7'b0000001) begin
          // M-op codes are contiguous from MUL in funct3 order
          w_dec.aluop = c_ALU_MUL + ALUOP_W'(w_f3);
          w_is_mop    = 1'b1;
`endif
        end else begin
          w_legal = 1'b0;
        end
      end
      c_OPC_OPIMM: begin
        w_dec.imm  = c_IMM_I;
        w_dec.mux2 = 1'b1;
        w_dec.we   = 1'b1;
        w_dec.f3   = w_f3;
        case (w_f3)
          3'b001: begin
            w_dec.aluop = c_ALU_SLL;
            w_legal     = (w_f7 == 7'b0000000);
          end
          3'b101: begin
            w_dec.aluop = (w_f7 == 7'b0100000) ? c_ALU_SRA : c_ALU_SRL;
            w_legal     = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          end
          default: w_dec.aluop = base_op(w_f3);
        endcase
      end
      c_OPC_LOAD: begin
        w_dec.aluop = c_ALU_ADD;
        w_dec.imm   = c_IMM_I;
        w_dec.mux2  = 1'b1;
        w_dec.mux4  = 1'b1;
        w_dec.mr    = 1'b1;
        w_dec.we    = 1'b1;
        w_dec.f3    = w_f3;
        w_legal     = w_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      c_OPC_STORE: begin
        w_dec.aluop = c_ALU_ADD;
        w_dec.imm   = c_IMM_S;
        w_dec.mux2  = 1'b1;
        w_dec.mw    = 1'b1;
        w_dec.f3    = w_f3;
        w_legal     = w_f3 inside {3'b000, 3'b001, 3'b010};
      end
      c_OPC_BRANCH: begin
        w_dec.aluop = c_ALU_SUB;
        w_dec.imm   = c_IMM_B;
        w_dec.mux1  = 1'b1;
        w_dec.mux2  = 1'b1;
        w_dec.br    = 1'b1;
        w_dec.f3    = w_f3;
        w_legal     = !(w_f3 inside {3'b010, 3'b011});
      end
      c_OPC_JAL: begin
        w_dec.aluop = c_ALU_ADD;
        w_dec.imm   = c_IMM_J;
        w_dec.mux1  = 1'b1;
        w_dec.mux2  = 1'b1;
        w_dec.mux3  = 1'b1;
        w_dec.jp    = 1'b1;
        w_dec.we    = 1'b1;
      end
      c_OPC_JALR: begin
        w_dec.aluop = c_ALU_ADD;
        w_dec.imm   = c_IMM_I;
        w_dec.mux2  = 1'b1;
        w_dec.mux3  = 1'b1;
        w_dec.jp    = 1'b1;
        w_dec.we    = 1'b1;
        w_dec.f3    = w_f3;
        w_legal     = (w_f3 == 3'b000);
      end
      c_OPC_LUI: begin
        w_dec.aluop = c_ALU_PASS_B;
        w_dec.imm   = c_IMM_U;
        w_dec.mux2  = 1'b1;
        w_dec.we    = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_dec.aluop = c_ALU_ADD;
        w_dec.imm   = c_IMM_U;
        w_dec.mux1  = 1'b1;
        w_dec.mux2  = 1'b1;
        w_dec.we    = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
    // An undecodable word becomes a bubble that only carries the ILLEGAL flag
    if (!w_legal) begin
      w_dec         = '0;
      w_dec.illegal = 1'b1;
`ifdef RV32M_EN
      w_is_mop      = 1'b0;
`endif
    end else begin
      w_dec.valid = 1'b1;
    end
  end

`ifdef RV32M_EN
  localparam int                CNT_W      = 5;
  localparam logic [CNT_W-1:0]  c_CNT_LOAD = CNT_W'(MD_LATENCY - 1);

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_MD_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_ctl   <= '0;
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (bus.FLUSH) begin
      r_ctl   <= '0;
      r_state <= S_RUN;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (r_state == S_MD_WAIT) begin
      // EX outputs held; leave at the edge where the counter reaches zero
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) begin
        r_state <= S_RUN;
        r_busy  <= 1'b0;
      end
    end else if (bus.STALL || !bus.IN_VALID) begin
      r_ctl <= '0;
    end else begin
      r_ctl <= w_dec;
      if (w_is_mop && (MD_LATENCY > 1)) begin
        r_state <= S_MD_WAIT;
        r_cnt   <= c_CNT_LOAD;
        r_busy  <= 1'b1;
      end
    end
  end

  assign bus.MD_BUSY = r_busy;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MD_LATENCY > 1);

  always_ff @(posedge CLK) begin
    if (!RESET || bus.FLUSH || bus.STALL || !bus.IN_VALID) begin
      r_ctl <= '0;
    end else begin
      r_ctl <= w_dec;
    end
  end

  assign bus.MD_BUSY = 1'b0;
`endif

  assign bus.ALUOP       = r_ctl.aluop;
  assign bus.IMME_SELECT = r_ctl.imm;
  assign bus.MUX1_SELECT = r_ctl.mux1;
  assign bus.MUX2_SELECT = r_ctl.mux2;
  assign bus.MUX3_SELECT = r_ctl.mux3;
  assign bus.MUX4_SELECT = r_ctl.mux4;
  assign bus.WRITEENABLE = r_ctl.we;
  assign bus.MEMREAD     = r_ctl.mr;
  assign bus.MEMWRITE    = r_ctl.mw;
  assign bus.BRANCH      = r_ctl.br;
  assign bus.JUMP        = r_ctl.jp;
  assign bus.FUNCT3_OUT  = r_ctl.f3;
  assign bus.OUT_VALID   = r_ctl.valid;
  assign bus.ILLEGAL     = r_ctl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_control_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipelined_control_unit : vector table, multi-cycle sequences, random run vs. pattern-table model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipelined_control_unit;

  localparam int LAT = 4;

  // flags: {mux1, mux2, mux3, mux4, we, memread, memwrite, branch, jump}
  localparam logic [8:0] FL_R     = 9'b000010000;
  localparam logic [8:0] FL_I     = 9'b010010000;
  localparam logic [8:0] FL_LD    = 9'b010111000;
  localparam logic [8:0] FL_ST    = 9'b010000100;
  localparam logic [8:0] FL_BR    = 9'b110000010;
  localparam logic [8:0] FL_JAL   = 9'b111010001;
  localparam logic [8:0] FL_JALR  = 9'b011010001;
  localparam logic [8:0] FL_AUIPC = 9'b110010000;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h00812283;
  localparam logic [31:0] MUL = 32'h022081B3;

  typedef struct packed {
    logic [4:0] alu;
    logic [2:0] imm;
    logic [8:0] fl;
    logic [2:0] f3;
    logic       valid;
    logic       ill;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    exp_t        e;
    bit          f3pass;
    bit          is_m;
  } pat_t;

  typedef struct {
    string       name;
    logic [31:0] ins;
    bit          v;
    bit          s;
    bit          f;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pat_t pats[$];
  vec_t vecs[$];
  exp_t act;
  exp_t m_out;
  longint edge_n    = 0;
  longint free_edge = 0;

  pipelined_control_unit_if #(.ALUOP_W(5), .IMM_SEL_W(3)) bus ();

  pipelined_control_unit #(
    .ALUOP_W(5), .IMM_SEL_W(3), .MD_LATENCY(LAT)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .bus  (bus)
  );

  assign act = {bus.ALUOP, bus.IMME_SELECT,
                bus.MUX1_SELECT, bus.MUX2_SELECT, bus.MUX3_SELECT, bus.MUX4_SELECT,
                bus.WRITEENABLE, bus.MEMREAD, bus.MEMWRITE, bus.BRANCH, bus.JUMP,
                bus.FUNCT3_OUT, bus.OUT_VALID, bus.ILLEGAL, bus.MD_BUSY};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(int alu, int imm, logic [8:0] fl, int f3, bit v, bit il, bit bz);
    exp_t r;
    r.alu = 5'(alu); r.imm = 3'(imm); r.fl = fl; r.f3 = 3'(f3);
    r.valid = v; r.ill = il; r.busy = bz;
    return r;
  endfunction

  task automatic addp(logic [31:0] mask, logic [31:0] match, int alu, int imm,
                      logic [8:0] fl, bit f3p, bit ism);
    pat_t p;
    p.mask = mask; p.match = match; p.e = E(alu, imm, fl, 0, 1, 0, 0);
    p.f3pass = f3p; p.is_m = ism;
    pats.push_back(p);
  endtask

  task automatic addv(string n, logic [31:0] ins, bit v, bit s, bit f, exp_t e);
    vec_t x;
    x.name = n; x.ins = ins; x.v = v; x.s = s; x.f = f; x.e = e;
    vecs.push_back(x);
  endtask

  // Legal instruction set as mask/match patterns, attributes per mnemonic
  task automatic build_patterns();
    int base_alu [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
    int imm_f3   [6] = '{0, 2, 3, 4, 6, 7};
    int ld_f3    [5] = '{0, 1, 2, 4, 5};
    int br_f3    [6] = '{0, 1, 4, 5, 6, 7};
    for (int f = 0; f < 8; f++)
      addp(32'hFE00707F, 32'h00000033 | (32'(f) << 12), base_alu[f], 0, FL_R, 1, 0);
    addp(32'hFE00707F, 32'h40000033, 2, 0, FL_R, 1, 0);
    addp(32'hFE00707F, 32'h40005033, 8, 0, FL_R, 1, 0);
`ifdef RV32M_EN
    for (int f = 0; f < 8; f++)
      addp(32'hFE00707F, 32'h02000033 | (32'(f) << 12), 11 + f, 0, FL_R, 1, 1);
`endif
    foreach (imm_f3[i])
      addp(32'h0000707F, 32'h00000013 | (32'(imm_f3[i]) << 12), base_alu[imm_f3[i]], 0, FL_I, 1, 0);
    addp(32'hFE00707F, 32'h00001013, 3, 0, FL_I, 1, 0);
    addp(32'hFE00707F, 32'h00005013, 7, 0, FL_I, 1, 0);
    addp(32'hFE00707F, 32'h40005013, 8, 0, FL_I, 1, 0);
    foreach (ld_f3[i]) addp(32'h0000707F, 32'h00000003 | (32'(ld_f3[i]) << 12), 1, 0, FL_LD, 1, 0);
    for (int f = 0; f < 3; f++) addp(32'h0000707F, 32'h00000023 | (32'(f) << 12), 1, 1, FL_ST, 1, 0);
    foreach (br_f3[i]) addp(32'h0000707F, 32'h00000063 | (32'(br_f3[i]) << 12), 2, 3, FL_BR, 1, 0);
    addp(32'h0000707F, 32'h00000067, 1, 0, FL_JALR, 1, 0);
    addp(32'h0000007F, 32'h0000006F, 1, 4, FL_JAL, 0, 0);
    addp(32'h0000007F, 32'h00000037, 0, 2, FL_I, 0, 0);
    addp(32'h0000007F, 32'h00000017, 1, 2, FL_AUIPC, 0, 0);
  endtask

  function automatic void model_decode(input logic [31:0] ins, output exp_t e, output bit ism);
    bit found = 0;
    e   = E(0, 0, 9'b0, 0, 0, 1, 0);
    ism = 0;
    foreach (pats[i]) begin
      if (!found && ((ins & pats[i].mask) == pats[i].match)) begin
        found = 1;
        e     = pats[i].e;
        if (pats[i].f3pass) e.f3 = ins[14:12];
        ism   = pats[i].is_m;
      end
    end
  endfunction

  // Timeline model: an M-op loaded at edge n occupies EX until edge n+LAT
  task automatic model_edge(bit rst, logic [31:0] ins, bit v, bit s, bit f);
    exp_t d;
    bit   ism;
    edge_n++;
    if (!rst || f) begin
      m_out     = '0;
      free_edge = 0;
    end else if (edge_n < free_edge) begin
      m_out = m_out;
    end else if (s || !v) begin
      m_out = '0;
    end else begin
      model_decode(ins, d, ism);
      m_out = d;
      if (ism) free_edge = edge_n + LAT;
    end
    m_out.busy = (edge_n + 1 < free_edge);
  endtask

  task automatic step(bit rst, logic [31:0] ins, bit v, bit s, bit f);
    rst_n           = rst;
    bus.INSTRUCTION = ins;
    bus.IN_VALID    = v;
    bus.STALL       = s;
    bus.FLUSH       = f;
    @(posedge clk);
    model_edge(rst, ins, v, s, f);
    @(negedge clk);
  endtask

  task automatic chk(string nm, exp_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, e);
    end
  endtask

  initial begin
    exp_t BUB;
    exp_t ILL;
    exp_t E_ADD;
    BUB   = '0;
    ILL   = E(0, 0, 9'b0, 0, 0, 1, 0);
    E_ADD = E(1, 0, FL_R, 0, 1, 0, 0);
    build_patterns();

    addv("add",          ADD,          1, 0, 0, E_ADD);
    addv("sub",          32'h402081B3, 1, 0, 0, E(2, 0, FL_R, 0, 1, 0, 0));
    addv("sra",          32'h4020D1B3, 1, 0, 0, E(8, 0, FL_R, 5, 1, 0, 0));
    addv("sltu",         32'h0020B1B3, 1, 0, 0, E(5, 0, FL_R, 3, 1, 0, 0));
    addv("sw",           32'h0020A423, 1, 0, 0, E(1, 1, FL_ST, 2, 1, 0, 0));
    addv("beq",          32'h00208463, 1, 0, 0, E(2, 3, FL_BR, 0, 1, 0, 0));
    addv("jal",          32'h008000EF, 1, 0, 0, E(1, 4, FL_JAL, 0, 1, 0, 0));
    addv("jalr",         32'h000080E7, 1, 0, 0, E(1, 0, FL_JALR, 0, 1, 0, 0));
    addv("lui",          32'h123450B7, 1, 0, 0, E(0, 2, FL_I, 0, 1, 0, 0));
    addv("auipc",        32'h00001097, 1, 0, 0, E(1, 2, FL_AUIPC, 0, 1, 0, 0));
    addv("srai",         32'h4030D093, 1, 0, 0, E(8, 0, FL_I, 5, 1, 0, 0));
    addv("xori",         32'hFFF0C093, 1, 0, 0, E(6, 0, FL_I, 4, 1, 0, 0));
    addv("slli bad f7",  32'h40309093, 1, 0, 0, ILL);
    addv("load bad f3",  32'h00813283, 1, 0, 0, ILL);
    addv("all ones",     32'hFFFFFFFF, 1, 0, 0, ILL);
    addv("ones invalid", 32'hFFFFFFFF, 0, 0, 0, BUB);
    addv("add invalid",  ADD,          0, 0, 0, BUB);
    addv("add stall",    ADD,          1, 1, 0, BUB);
    addv("flush+stall",  ADD,          1, 1, 1, BUB);
    addv("add again",    ADD,          1, 0, 0, E_ADD);

    step(0, ADD, 1, 0, 0);
    chk("reset", BUB);
    step(1, ADD, 0, 0, 0);
    chk("idle after reset", BUB);

    foreach (vecs[i]) begin
      step(1, vecs[i].ins, vecs[i].v, vecs[i].s, vecs[i].f);
      chk(vecs[i].name, vecs[i].e);
    end

    step(1, LW, 1, 1, 0);
    chk("lw stalled", BUB);
    step(1, LW, 1, 0, 0);
    chk("lw", E(1, 0, FL_LD, 2, 1, 0, 0));

`ifdef RV32M_EN
    step(1, MUL, 1, 0, 0);
    chk("mul enter", E(11, 0, FL_R, 0, 1, 0, LAT > 1));
    for (int k = 1; k < LAT; k++) begin
      step(1, ADD, 1, (k == 1), 0);
      chk($sformatf("mul hold %0d", k), E(11, 0, FL_R, 0, 1, 0, k < LAT - 1));
    end
    step(1, ADD, 1, 0, 0);
    chk("load after mul", E_ADD);

    step(1, 32'h0220C1B3, 1, 0, 0);
    chk("div enter", E(15, 0, FL_R, 4, 1, 0, 1));
    step(1, ADD, 1, 0, 0);
    chk("div wait 1", E(15, 0, FL_R, 4, 1, 0, 1));
    step(1, ADD, 1, 1, 1);
    chk("flush in wait", BUB);
    step(1, ADD, 1, 0, 0);
    chk("load after flush", E_ADD);

    step(1, MUL, 1, 0, 0);
    step(0, ADD, 1, 0, 0);
    chk("reset aborts mop", BUB);
    step(1, ADD, 1, 0, 0);
    chk("load after reset", E_ADD);
`else
    step(1, MUL, 1, 0, 0);
    chk("mul illegal", ILL);
    step(1, ADD, 1, 0, 0);
    chk("add after mul", E_ADD);
`endif

    step(0, 32'h0, 0, 0, 0);
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ins;
      int          r;
      int          p;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        p   = $urandom_range(0, pats.size() - 1);
        ins = ($urandom() & ~pats[p].mask) | pats[p].match;
      end else if (r < 80) begin
        ins = ($urandom() & ~32'hFE00707F) | 32'h02000033 | (32'($urandom_range(0, 7)) << 12);
      end else begin
        ins = $urandom();
      end
      step($urandom_range(0, 99) != 0, ins, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4);
      chk("random", m_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
